systolic_result_drain: RTL and testbench



---
 rtl/sys_pkg.sv | 16 +
 rtl/drain_fifo.sv | 54 +++++
 rtl/systolic_result_drain.sv | 125 ++++++++++++
 tb/tb_systolic_result_drain.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_pkg.sv
// sys_pkg: shared widths and helpers for the systolic array slice.
// Packed lane i of an N*W bus sits at [lane_lsb(i, W) +: W].
package sys_pkg;

  localparam int D_W     = 16;
  localparam int D_W_ACC = 64;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int lane_lsb(input int i, input int w);
    return i * w;
  endfunction

endpackage

// File: rtl/drain_fifo.sv
// drain_fifo: sync FIFO, async active-low reset, sync clear.
// Ports: push/wdata in, pop/rdata out (show-ahead), full/empty.
module drain_fifo
  import sys_pkg::*;
#(
  parameter int W     = D_W_ACC,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = idx_w(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // a pop frees the slot, so a full FIFO may still take a push
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: per-row FIFOs serialised row-major onto
// m_data/m_valid/m_ready; m_last ends a matrix; overflow is sticky.
// In: clk, rst_n, clear, in_data[N*D_W_ACC], in_valid[N], m_ready.
// Optional SYS_DRAIN_TAG_EN adds m_row/m_col word tags.
module systolic_result_drain
  import sys_pkg::*;
#(
  parameter int N          = 4,
  parameter int D_W_ACC    = sys_pkg::D_W_ACC,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [N*D_W_ACC-1:0] in_data,
  input  logic [N-1:0]         in_valid,
  output logic [D_W_ACC-1:0]   m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic [N-1:0]         overflow
`ifdef SYS_DRAIN_TAG_EN
  ,
  output logic [idx_w(N)-1:0]  m_row,
  output logic [idx_w(N)-1:0]  m_col
`endif
);

  localparam int IW = idx_w(N);
  localparam logic [IW-1:0] LAST = IW'(N-1);

  logic [D_W_ACC-1:0] head [N];
  logic [N-1:0]       full;
  logic [N-1:0]       empty;
  logic [N-1:0]       pop;
  logic [IW-1:0]      row_idx;
  logic [IW-1:0]      col_idx;
  logic [IW-1:0]      row_nxt;
  logic [IW-1:0]      col_nxt;
  logic               load;
  logic               row_end;
  logic               mat_end;

  // strict row-major: a missing word stalls, never skipped
  assign load    = (~m_valid | m_ready) & ~empty[row_idx];
  assign row_end = col_idx == LAST;
  assign mat_end = row_end && (row_idx == LAST);

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign pop[i] = load && (row_idx == IW'(i));

    drain_fifo #(
      .W     (D_W_ACC),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .push  (in_valid[i]),
      .wdata (in_data[lane_lsb(i, D_W_ACC) +: D_W_ACC]),
      .pop   (pop[i]),
      .rdata (head[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  always_comb begin
    col_nxt = col_idx + IW'(1);
    row_nxt = row_idx;
    unique case (1'b1)
      mat_end: begin
        col_nxt = '0;
        row_nxt = '0;
      end
      row_end && !mat_end: begin
        col_nxt = '0;
        row_nxt = row_idx + IW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_idx  <= '0;
      col_idx  <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
      overflow <= '0;
`ifdef SYS_DRAIN_TAG_EN
      m_row    <= '0;
      m_col    <= '0;
`endif
    end else if (clear) begin
      row_idx  <= '0;
      col_idx  <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
      overflow <= '0;
`ifdef SYS_DRAIN_TAG_EN
      m_row    <= '0;
      m_col    <= '0;
`endif
    end else begin
      overflow <= overflow | (in_valid & full & ~pop);
      if (load) begin
        m_valid <= 1'b1;
        m_data  <= head[row_idx];
        m_last  <= mat_end;
        row_idx <= row_nxt;
        col_idx <= col_nxt;
`ifdef SYS_DRAIN_TAG_EN
        m_row   <= row_idx;
        m_col   <= col_idx;
`endif
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// tb_systolic_result_drain: randomized and directed checks of the
// drain against a row-major word-order reference model.
module tb_systolic_result_drain;

  localparam int N = 4;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           clear = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic           m_ready = 1'b0;
  logic [W-1:0]   m_data;
  logic           m_valid;
  logic           m_last;
  logic [N-1:0]   overflow;
`ifdef SYS_DRAIN_TAG_EN
  logic [1:0]     m_row;
  logic [1:0]     m_col;
`endif

  int total = 0;
  int bad = 0;
  logic [W-1:0] lw [N][16];
  int wcnt [N];
  int n_out;

  systolic_result_drain #(
    .N          (N),
    .D_W_ACC    (W),
    .FIFO_DEPTH (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_data  (in_data),
    .in_valid (in_valid),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .overflow (overflow)
`ifdef SYS_DRAIN_TAG_EN
    ,
    .m_row    (m_row),
    .m_col    (m_col)
`endif
  );

  always #5 clk = ~clk;

  // word k of the output stream: matrix k/16, row (k/4)%4, col k%4
  function automatic logic [W-1:0] exp_word(input int k);
    return lw[(k / 4) % N][(k / 16) * 4 + k % 4];
  endfunction

  task automatic set_mat(input bit dir);
    for (int i = 0; i < N; i++) begin
      wcnt[i] = 0;
      for (int j = 0; j < 16; j++)
        lw[i][j] = dir ? W'(i * 16 + j) : {$urandom, $urandom};
    end
    n_out = 0;
  endtask

  // one cycle: drive after the edge, return at the falling edge
  task automatic step(input logic [N-1:0] v, input logic rdy,
                      input logic clr);
    @(posedge clk);
    #1;
    clear = clr;
    m_ready = rdy;
    in_valid = v;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        in_data[i*W +: W] = lw[i][wcnt[i]];
        wcnt[i]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    in_valid = '0;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      step('0, 1'b0, 1'b0);
      total++;
      if ({m_valid, m_last, overflow, m_data} !== '0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d v=%b ov=%b d=%h exp=0",
                 k, m_valid, overflow, m_data);
      end
    end
  endtask

  task automatic test_ordered();
    logic [N-1:0] v;
    int first;
    set_mat(1'b1);
    first = -1;
    for (int k = 0; k < 80 && n_out < 16; k++) begin
      v = '0;
      for (int i = 0; i < N; i++)
        if (k >= 3 - i && wcnt[i] < 4) v[i] = 1'b1;
      step(v, 1'b1, 1'b0);
      if (m_valid && first < 0) first = k;
      if (m_valid && m_ready) begin
        total++;
        if (n_out >= 16 || m_data !== exp_word(n_out) ||
            m_last !== (n_out % 16 == 15)) begin
          bad++;
          $display("FAIL ordered n=%0d got=%h/%b exp=%h/%b", n_out,
                   m_data, m_last, exp_word(n_out % 16),
                   n_out % 16 == 15);
        end
        n_out++;
      end
    end
    total++;
    if (first != 5) begin
      bad++;
      $display("FAIL ordered_latency got=%0d exp=5", first);
    end
    total++;
    if (n_out != 16) begin
      bad++;
      $display("FAIL ordered_count got=%0d exp=16", n_out);
    end
    step('0, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    total++;
    if (m_valid !== 1'b0) begin
      bad++;
      $display("FAIL ordered_extra got=%b exp=0", m_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] v;
    logic         rdy;
    logic         stall;
    logic [W-1:0] sd;
    logic         sl;
    int           st [N];
    for (int rep = 0; rep < 3; rep++) begin
      set_mat(1'b0);
      stall = 1'b0;
      sd = '0;
      sl = 1'b0;
      for (int i = 0; i < N; i++) st[i] = $urandom_range(0, 6);
      for (int k = 0; k < 400 && n_out < 16; k++) begin
        v = '0;
        for (int i = 0; i < N; i++)
          if (k >= st[i] && wcnt[i] < 4 && ($urandom % 2) == 1)
            v[i] = 1'b1;
        rdy = 1'($urandom % 2);
        step(v, rdy, 1'b0);
        if (stall) begin
          total++;
          if (!m_valid || m_data !== sd || m_last !== sl) begin
            bad++;
            $display("FAIL bp_stable got=%b/%h exp=1/%h",
                     m_valid, m_data, sd);
          end
        end
        stall = m_valid && !m_ready;
        sd = m_data;
        sl = m_last;
        if (m_valid && m_ready) begin
          total++;
          if (n_out >= 16 || m_data !== exp_word(n_out) ||
              m_last !== (n_out % 16 == 15)) begin
            bad++;
            $display("FAIL bp_order n=%0d got=%h exp=%h", n_out,
                     m_data, exp_word(n_out % 16));
          end
          n_out++;
        end
      end
      total++;
      if (n_out != 16) begin
        bad++;
        $display("FAIL bp_count got=%0d exp=16", n_out);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    set_mat(1'b0);
    for (int k = 0; k < 9; k++) step(4'b0100, 1'b0, 1'b0);
    total++;
    if (overflow !== 4'b0000) begin
      bad++;
      $display("FAIL ovf_early got=%b exp=0000", overflow);
    end
    step('0, 1'b0, 1'b0);
    total++;
    if (overflow !== 4'b0100) begin
      bad++;
      $display("FAIL ovf_set got=%b exp=0100", overflow);
    end
    for (int k = 0; k < 300 && n_out < 32; k++) begin
      step((wcnt[0] < 8) ? 4'b1011 : 4'b0000,
           1'($urandom % 2), 1'b0);
      if (m_valid && m_ready) begin
        total++;
        if (n_out >= 32 || m_data !== exp_word(n_out) ||
            m_last !== (n_out % 16 == 15)) begin
          bad++;
          $display("FAIL ovf_order n=%0d got=%h exp=%h", n_out,
                   m_data, exp_word(n_out % 32));
        end
        n_out++;
      end
    end
    total++;
    if (n_out != 32) begin
      bad++;
      $display("FAIL ovf_count got=%0d exp=32", n_out);
    end
    repeat (3) step('0, 1'b1, 1'b0);
    total++;
    if (m_valid !== 1'b0 || overflow !== 4'b0100) begin
      bad++;
      $display("FAIL ovf_tail got=%b/%b exp=0/0100",
               m_valid, overflow);
    end
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0);
    total++;
    if (overflow !== 4'b0000) begin
      bad++;
      $display("FAIL ovf_clear got=%b exp=0000", overflow);
    end
  endtask

  task automatic test_full_pop();
    logic [N-1:0] v;
    logic         rdy;
    int           ln;
    do_reset();
    set_mat(1'b0);
    for (int k = 0; k < 200 && n_out < 48; k++) begin
      v = '0;
      rdy = 1'b1;
      if (k < 9) begin
        v = 4'b0001;
        rdy = 1'b0;
      end else if (k == 9) begin
        rdy = 1'b0;
      end else if (k == 10) begin
        v = 4'b0001;
      end else begin
        v[0] = wcnt[0] < 12;
        ln = 1 + (k - 11) % 3;
        v[ln] = wcnt[ln] < 12;
      end
      step(v, rdy, 1'b0);
      if (k == 9) begin
        total++;
        if (!m_valid || m_data !== lw[0][0]) begin
          bad++;
          $display("FAIL fp_hold got=%b/%h exp=1/%h",
                   m_valid, m_data, lw[0][0]);
        end
      end
      if (k == 11) begin
        total++;
        if (overflow !== 4'b0000) begin
          bad++;
          $display("FAIL fp_no_ovf got=%b exp=0000", overflow);
        end
      end
      if (m_valid && m_ready) begin
        total++;
        if (n_out >= 48 || m_data !== exp_word(n_out) ||
            m_last !== (n_out % 16 == 15)) begin
          bad++;
          $display("FAIL fp_order n=%0d got=%h exp=%h", n_out,
                   m_data, exp_word(n_out % 48));
        end
        n_out++;
      end
    end
    total++;
    if (n_out != 48 || overflow !== 4'b0000) begin
      bad++;
      $display("FAIL fp_end got=%0d/%b exp=48/0000", n_out, overflow);
    end
  endtask

  task automatic test_midflush(input bit use_rst);
    logic [N-1:0] v;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      set_mat(1'b0);
      for (int k = 0; k < 80 && n_out < 16; k++) begin
        if (pass == 0 && n_out == 6) break;
        v = '0;
        for (int i = 0; i < N; i++)
          if (k >= 3 - i && wcnt[i] < 4) v[i] = 1'b1;
        step(v, 1'b1, 1'b0);
        if (m_valid && m_ready) begin
          total++;
          if (n_out >= 16 || m_data !== exp_word(n_out) ||
              m_last !== (n_out % 16 == 15)) begin
            bad++;
            $display("FAIL flush%0d_order p=%0d n=%0d got=%h exp=%h",
                     use_rst, pass, n_out, m_data,
                     exp_word(n_out % 16));
          end
          n_out++;
        end
      end
      if (pass == 0) begin
        total++;
        if (n_out != 6) begin
          bad++;
          $display("FAIL flush%0d_pre got=%0d exp=6", use_rst, n_out);
        end
        if (use_rst) begin
          @(posedge clk);
          #3;
          in_valid = '0;
          rst_n = 1'b0;
          #1;
          total++;
          if (m_valid !== 1'b0 || m_data !== '0) begin
            bad++;
            $display("FAIL flush1_async got=%b/%h exp=0/0",
                     m_valid, m_data);
          end
          @(posedge clk);
          #2;
          rst_n = 1'b1;
        end else begin
          step('0, 1'b1, 1'b1);
          step('0, 1'b1, 1'b0);
          total++;
          if (m_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush0_clear got=%b exp=0", m_valid);
          end
        end
      end
    end
    total++;
    if (n_out != 16) begin
      bad++;
      $display("FAIL flush%0d_count got=%0d exp=16", use_rst, n_out);
    end
  endtask

  initial begin
    test_reset();
    test_ordered();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_midflush(1'b0);
    test_midflush(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
